// File: rtl/touch_key_decoder_if.sv
// Coordinate/strobe inputs and key event outputs between touch_top and the key decoder.
// master = touch controller side, slave = decoder side.
interface touch_key_decoder_if;
    logic [31:0] touch_data;
    logic        touch_valid;
    logic [3:0]  key_code;
    logic        key_hold;
    logic        key_press;
    logic        key_release;

    modport master (
        output touch_data,
        output touch_valid,
        input  key_code,
        input  key_hold,
        input  key_press,
        input  key_release
    );

    modport slave (
        input  touch_data,
        input  touch_valid,
        output key_code,
        output key_hold,
        output key_press,
        output key_release
    );
endinterface

// File: rtl/touch_key_decoder.sv
// Maps touch samples onto a key grid by iterative subtraction, debounces consecutive hits
// and emits key press/hold/release events.
module touch_key_decoder #(
    parameter logic [15:0] X0          = 16'd40,
    parameter logic [15:0] Y0          = 16'd160,
    parameter logic [15:0] KEY_W       = 16'd180,
    parameter logic [15:0] KEY_H       = 16'd140,
    parameter int unsigned KEY_COLS    = 4,
    parameter int unsigned KEY_ROWS    = 3,
    parameter int unsigned DEB_SAMPLES = 3,
    parameter logic [23:0] REL_CLKS    = 24'd2500000
) (
    input logic                sys_clk,
    input logic                sys_rst_n,
    touch_key_decoder_if.slave bus
);
    localparam logic [3:0] COLS4 = 4'(KEY_COLS);
    localparam logic [3:0] ROWS4 = 4'(KEY_ROWS);
    localparam logic [3:0] DEB4  = 4'(DEB_SAMPLES);

    typedef enum logic [0:0] {SampIdle, SampCalc} samp_state_e;
    typedef enum logic [1:0] {KeyIdle, KeyDebounce, KeyHeld} key_state_e;

    samp_state_e r_samp_state;
    key_state_e  r_key_state;
    logic [2:0]  r_step;
    logic [15:0] r_dx;
    logic [15:0] r_dy;
    logic [3:0]  r_col;
    logic [3:0]  r_row;
    logic        r_oob;
    logic        r_res_valid;
    logic [23:0] r_to_cnt;
    logic [3:0]  r_cand;
    logic [3:0]  r_cnt;
    logic [3:0]  r_key_code;
    logic        r_key_hold;
    logic        r_key_press;
    logic        r_key_release;

    logic        w_timeout;
    logic        w_hit;
    logic [3:0]  w_key;
    logic [15:0] w_x;
    logic [15:0] w_y;

    assign w_x       = bus.touch_data[31:16];
    assign w_y       = bus.touch_data[15:0];
    assign w_timeout = (r_to_cnt == REL_CLKS - 24'd1);
    // A missing result with a timeout is handled exactly like a miss, so the result wins.
    assign w_hit     = r_res_valid && !r_oob && (r_col < COLS4) && (r_row < ROWS4);
    assign w_key     = r_row * COLS4 + r_col;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_samp_state <= SampIdle;
            r_step       <= '0;
            r_dx         <= '0;
            r_dy         <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_oob        <= 1'b0;
            r_res_valid  <= 1'b0;
            r_to_cnt     <= '0;
        end else begin
            r_res_valid <= 1'b0;
            if (bus.touch_valid) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != REL_CLKS) begin
                r_to_cnt <= r_to_cnt + 24'd1;
            end
            case (r_samp_state)
                SampIdle: begin
                    if (bus.touch_valid) begin
                        r_oob        <= (w_x < X0) || (w_y < Y0);
                        r_dx         <= w_x - X0;
                        r_dy         <= w_y - Y0;
                        r_col        <= '0;
                        r_row        <= '0;
                        r_step       <= '0;
                        r_samp_state <= SampCalc;
                    end
                end
                SampCalc: begin
                    // Eight steps cover up to 8 columns/rows; anything beyond saturates into a miss.
                    if (r_dx >= KEY_W) begin
                        r_dx  <= r_dx - KEY_W;
                        r_col <= r_col + 4'd1;
                    end
                    if (r_dy >= KEY_H) begin
                        r_dy  <= r_dy - KEY_H;
                        r_row <= r_row + 4'd1;
                    end
                    r_step <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_samp_state <= SampIdle;
                        r_res_valid  <= 1'b1;
                    end
                end
                default: r_samp_state <= SampIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_key_state   <= KeyIdle;
            r_cand        <= '0;
            r_cnt         <= '0;
            r_key_code    <= '0;
            r_key_hold    <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            if (r_res_valid || w_timeout) begin
                unique case (r_key_state)
                    KeyIdle: begin
                        if (w_hit) begin
                            r_cand <= w_key;
                            r_cnt  <= 4'd1;
                            if (DEB4 == 4'd1) begin
                                r_key_state <= KeyHeld;
                                r_key_code  <= w_key;
                                r_key_hold  <= 1'b1;
                                r_key_press <= 1'b1;
                            end else begin
                                r_key_state <= KeyDebounce;
                            end
                        end
                    end
                    KeyDebounce: begin
                        if (w_hit && (w_key == r_cand)) begin
                            r_cnt <= r_cnt + 4'd1;
                            if (r_cnt + 4'd1 == DEB4) begin
                                r_key_state <= KeyHeld;
                                r_key_code  <= r_cand;
                                r_key_hold  <= 1'b1;
                                r_key_press <= 1'b1;
                            end
                        end else if (w_hit) begin
                            r_cand <= w_key;
                            r_cnt  <= 4'd1;
                        end else begin
                            r_key_state <= KeyIdle;
                        end
                    end
                    KeyHeld: begin
                        // A different key releases only; its sample does not start a debounce.
                        if (!(w_hit && (w_key == r_key_code))) begin
                            r_key_state   <= KeyIdle;
                            r_key_hold    <= 1'b0;
                            r_key_release <= 1'b1;
                        end
                    end
                    default: r_key_state <= KeyIdle;
                endcase
            end
        end
    end

    assign bus.key_code    = r_key_code;
    assign bus.key_hold    = r_key_hold;
    assign bus.key_press   = r_key_press;
    assign bus.key_release = r_key_release;
endmodule

// File: tb/tb_touch_key_decoder.sv
// Self-checking bench: event-level reference model of the key decoder plus directed literal checks
// and a randomized strobe stream.
module tb_touch_key_decoder;
    localparam int REL  = 100;
    localparam int X0   = 40;
    localparam int Y0   = 160;
    localparam int KW   = 180;
    localparam int KH   = 140;
    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int DEB  = 3;
    localparam int LAT  = 9;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;

    touch_key_decoder_if u_bus ();

    touch_key_decoder #(
        .REL_CLKS (24'd100)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (u_bus)
    );

    always #5 sys_clk = ~sys_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: k = index of the last evaluated rising edge.
    typedef struct {
        int due;
        bit hit;
        int key;
    } res_t;

    res_t q[$];
    int   k         = 0;
    int   last_v    = 0;
    int   mode      = 0;  // 0 idle, 1 debouncing, 2 held
    int   cand      = 0;
    int   cnt       = 0;
    int   exp_code  = 0;
    bit   exp_hold  = 1'b0;
    bit   exp_press = 1'b0;
    bit   exp_rel   = 1'b0;

    function automatic void decode(input int x, input int y, output bit hit, output int key);
        int col;
        int row;
        hit = 1'b0;
        key = 0;
        if (x >= X0 && y >= Y0) begin
            col = (x - X0) / KW;
            row = (y - Y0) / KH;
            if (col < COLS && row < ROWS) begin
                hit = 1'b1;
                key = row * COLS + col;
            end
        end
    endfunction

    task automatic apply(input bit hit, input int key);
        case (mode)
            0: begin
                if (hit) begin
                    cand = key;
                    cnt  = 1;
                    if (DEB == 1) begin
                        mode = 2; exp_code = key; exp_hold = 1'b1; exp_press = 1'b1;
                    end else begin
                        mode = 1;
                    end
                end
            end
            1: begin
                if (hit && key == cand) begin
                    cnt++;
                    if (cnt == DEB) begin
                        mode = 2; exp_code = cand; exp_hold = 1'b1; exp_press = 1'b1;
                    end
                end else if (hit) begin
                    cand = key;
                    cnt  = 1;
                end else begin
                    mode = 0;
                end
            end
            default: begin
                if (!(hit && key == exp_code)) begin
                    exp_rel  = 1'b1;
                    exp_hold = 1'b0;
                    mode     = 0;
                end
            end
        endcase
    endtask

    initial forever begin
        @(posedge sys_clk or negedge sys_rst_n);
        if (!sys_rst_n) begin
            q.delete();
            mode = 0; cand = 0; cnt = 0;
            exp_code = 0; exp_hold = 1'b0; exp_press = 1'b0; exp_rel = 1'b0;
            last_v = k;
        end else begin
            res_t r;
            res_t n;
            bit   have;
            bit   tmo;
            k++;
            have = 1'b0;
            if (q.size() > 0 && q[0].due == k) begin
                r    = q.pop_front();
                have = 1'b1;
            end
            tmo = ((k - 1 - last_v) == REL - 1);
            if (u_bus.touch_valid) begin
                last_v = k;
                if (q.size() == 0) begin
                    n.due = k + LAT;
                    decode(int'(u_bus.touch_data[31:16]), int'(u_bus.touch_data[15:0]), n.hit, n.key);
                    q.push_back(n);
                end
            end
            exp_press = 1'b0;
            exp_rel   = 1'b0;
            if (have) apply(r.hit, r.key);
            else if (tmo) apply(1'b0, 0);
        end
    end

    initial forever begin
        @(negedge sys_clk);
        vectors++;
        if (u_bus.key_code !== 4'(exp_code) || u_bus.key_hold !== exp_hold ||
            u_bus.key_press !== exp_press || u_bus.key_release !== exp_rel) begin
            miscompares++;
            $display("FAIL model edge=%0d got code=%0d hold=%b press=%b rel=%b want code=%0d hold=%b press=%b rel=%b",
                     k, u_bus.key_code, u_bus.key_hold, u_bus.key_press, u_bus.key_release,
                     exp_code, exp_hold, exp_press, exp_rel);
        end
    end

    task automatic chk(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s edge=%0d got=%0d want=%0d", name, k, got, want);
        end
    endtask

    task automatic do_reset(input bit rnd);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        repeat (4) begin
            @(negedge sys_clk);
            if (rnd) begin
                u_bus.touch_valid = 1'($urandom);
                u_bus.touch_data  = $urandom;
            end
        end
        u_bus.touch_valid = 1'b0;
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
    endtask

    task automatic strobe(input int x, input int y, output int s);
        @(negedge sys_clk);
        u_bus.touch_data  = {16'(x), 16'(y)};
        u_bus.touch_valid = 1'b1;
        @(negedge sys_clk);
        u_bus.touch_valid = 1'b0;
        s = k;
    endtask

    // Strobe whose edge lies g clocks after the previous strobe edge.
    task automatic gstrobe(input int x, input int y, input int g, output int s);
        repeat (g - 2) @(negedge sys_clk);
        strobe(x, y, s);
    endtask

    task automatic wait_to(input int e);
        if (e > k) repeat (e - k) @(negedge sys_clk);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, " code"}, int'(u_bus.key_code), 0);
        chk({name, " hold"}, int'(u_bus.key_hold), 0);
        chk({name, " press"}, int'(u_bus.key_press), 0);
        chk({name, " rel"}, int'(u_bus.key_release), 0);
    endtask

    int ex_x[4]    = '{39, 40, 759, 760};
    int ex_y[4]    = '{445, 160, 579, 579};
    int ex_hold[4] = '{0, 1, 1, 0};
    int ex_code[4] = '{0, 0, 11, 0};

    initial begin
        int s;
        int x;
        int y;
        int g;
        int rr;
        int kk;
        u_bus.touch_valid = 1'b0;
        u_bus.touch_data  = '0;

        // Reset with noisy inputs, then quiet.
        do_reset(1'b1);
        chk_idle_outputs("reset");
        repeat (5) @(negedge sys_clk);
        chk_idle_outputs("post reset");

        // Press on key 9, then timeout release.
        strobe(230, 445, s);
        gstrobe(230, 445, 20, s);
        gstrobe(230, 445, 20, s);
        wait_to(s + 8);
        chk("press early", int'(u_bus.key_press), 0);
        chk("hold early", int'(u_bus.key_hold), 0);
        wait_to(s + 9);
        chk("press k9", int'(u_bus.key_press), 1);
        chk("code k9", int'(u_bus.key_code), 9);
        chk("hold k9", int'(u_bus.key_hold), 1);
        wait_to(s + 99);
        chk("rel early", int'(u_bus.key_release), 0);
        chk("hold pre-timeout", int'(u_bus.key_hold), 1);
        wait_to(s + 100);
        chk("rel timeout", int'(u_bus.key_release), 1);
        chk("hold timeout", int'(u_bus.key_hold), 0);
        chk("code kept", int'(u_bus.key_code), 9);

        // Re-hold key 9, then a miss releases it.
        strobe(230, 445, s);
        gstrobe(230, 445, 20, s);
        gstrobe(230, 445, 20, s);
        gstrobe(10, 10, 20, s);
        wait_to(s + 9);
        chk("rel miss", int'(u_bus.key_release), 1);
        chk("hold miss", int'(u_bus.key_hold), 0);

        // Grid edges.
        for (int i = 0; i < 4; i++) begin
            do_reset(1'b0);
            strobe(ex_x[i], ex_y[i], s);
            gstrobe(ex_x[i], ex_y[i], 20, s);
            gstrobe(ex_x[i], ex_y[i], 20, s);
            wait_to(s + 9);
            chk($sformatf("edge%0d hold", i), int'(u_bus.key_hold), ex_hold[i]);
            chk($sformatf("edge%0d code", i), int'(u_bus.key_code), ex_code[i]);
        end

        // Debounce restart: key 5 twice then key 6 three times.
        do_reset(1'b0);
        strobe(250, 310, s);
        gstrobe(250, 310, 20, s);
        gstrobe(430, 310, 20, s);
        gstrobe(430, 310, 20, s);
        wait_to(s + 9);
        chk("restart no press", int'(u_bus.key_hold), 0);
        gstrobe(430, 310, 20, s);
        wait_to(s + 9);
        chk("restart press", int'(u_bus.key_press), 1);
        chk("restart code", int'(u_bus.key_code), 6);

        // Overlapping strobe is ignored; async reset while held.
        do_reset(1'b0);
        strobe(230, 445, s);
        gstrobe(230, 445, 4, s);
        gstrobe(230, 445, 20, s);
        wait_to(s + 9);
        chk("overlap ignored", int'(u_bus.key_hold), 0);
        gstrobe(230, 445, 20, s);
        wait_to(s + 9);
        chk("overlap press", int'(u_bus.key_press), 1);
        @(negedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1;
        chk("async hold", int'(u_bus.key_hold), 0);
        chk("async code", int'(u_bus.key_code), 0);
        chk("async rel", int'(u_bus.key_release), 0);
        repeat (2) @(negedge sys_clk);
        #2 sys_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);

        // Randomized strobe stream against the model.
        do_reset(1'b0);
        x = 230;
        y = 445;
        for (int i = 0; i < 300; i++) begin
            rr = $urandom_range(0, 99);
            if (rr >= 65 && rr < 90) begin
                kk = $urandom_range(0, COLS * ROWS - 1);
                x  = X0 + (kk % COLS) * KW + $urandom_range(0, KW - 1);
                y  = Y0 + (kk / COLS) * KH + $urandom_range(0, KH - 1);
            end else if (rr >= 90) begin
                x = $urandom_range(0, 900);
                y = $urandom_range(0, 700);
            end
            rr = $urandom_range(0, 99);
            if (rr < 10) g = $urandom_range(2, 8);
            else if (rr < 20) g = $urandom_range(90, 130);
            else g = $urandom_range(9, 30);
            gstrobe(x, y, g, s);
        end
        repeat (150) @(negedge sys_clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
